// File: rtl/mem_req_demux2_pkg.sv
// Shared memory-bus definitions: request FSM state encoding and default
// address-map / error constants used by the data-side request demux.
package mem_req_demux2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hBFAF_0000;
  localparam logic [31:0] MMIO_SIZE_DEF = 32'h0001_0000;
  localparam logic [31:0] ERR_DATA_DEF  = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_req_demux2_addr_decode.sv
// Combinational address-to-slave select: 1 when addr falls in the MMIO window.
module mem_req_demux2_addr_decode #(
  parameter int            AW   = 32,
  parameter logic [AW-1:0] BASE = '0,
  parameter logic [AW-1:0] SIZE = '0
) (
  input  logic [AW-1:0] addr,
  output logic          sel
);

  logic          above_base;
  logic [AW-1:0] offset;

  // The base check guards the subtraction, so a wrapped offset never selects.
  assign above_base = (addr >= BASE);
  assign offset     = addr - BASE;
  assign sel        = above_base && (offset < SIZE);

endmodule

// File: rtl/mem_req_demux2.sv
// Steers one CPU data request to data RAM (slave 0) or the MMIO window
// (slave 1) and returns that slave's response; a watchdog ends hung accesses.
//
// state   | meaning
// IDLE    | ready for a CPU request
// REQ     | holding sN_req on the selected slave until it acks
// RESP    | request accepted by slave, waiting for its rvalid
module mem_req_demux2
  import mem_req_demux2_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter logic [AW-1:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter logic [AW-1:0] MMIO_SIZE = MMIO_SIZE_DEF,
  parameter int            TIMEOUT   = 255,
  parameter logic [DW-1:0] ERR_DATA  = ERR_DATA_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  input  logic [DW/8-1:0] cpu_be,
  output logic            cpu_ready,
  output logic            cpu_rvalid,
  output logic [DW-1:0]   cpu_rdata,
  output logic            cpu_err,
  output logic            s0_req,
  output logic            s0_we,
  output logic [AW-1:0]   s0_addr,
  output logic [DW-1:0]   s0_wdata,
  output logic [DW/8-1:0] s0_be,
  input  logic            s0_ack,
  input  logic            s0_rvalid,
  input  logic [DW-1:0]   s0_rdata,
  output logic            s1_req,
  output logic            s1_we,
  output logic [AW-1:0]   s1_addr,
  output logic [DW-1:0]   s1_wdata,
  output logic [DW/8-1:0] s1_be,
  input  logic            s1_ack,
  input  logic            s1_rvalid,
  input  logic [DW-1:0]   s1_rdata
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);

  bus_state_e      state;
  logic [CW-1:0]   cnt;
  logic            lat_sel;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic [DW/8-1:0] lat_be;

  logic            dec_sel;
  logic            sel_ack;
  logic            sel_rvalid;
  logic [DW-1:0]   sel_rdata;
  logic            rsp_ok;
  logic            to_hit;

  mem_req_demux2_addr_decode #(
    .AW   (AW),
    .BASE (MMIO_BASE),
    .SIZE (MMIO_SIZE)
  ) u_addr_decode (
    .addr (cpu_addr),
    .sel  (dec_sel)
  );

  // Only the latched slave's return path is ever looked at.
  assign sel_ack    = lat_sel ? s1_ack    : s0_ack;
  assign sel_rvalid = lat_sel ? s1_rvalid : s0_rvalid;
  assign sel_rdata  = lat_sel ? s1_rdata  : s0_rdata;

  assign rsp_ok = ((state == ST_REQ) && sel_ack && sel_rvalid) ||
                  ((state == ST_RESP) && sel_rvalid);
  assign to_hit = (state != ST_IDLE) && (cnt == TO_LAST);

  assign s0_we    = lat_we;
  assign s0_addr  = lat_addr;
  assign s0_wdata = lat_wdata;
  assign s0_be    = lat_be;
  assign s1_we    = lat_we;
  assign s1_addr  = lat_addr;
  assign s1_wdata = lat_wdata;
  assign s1_be    = lat_be;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lat_sel    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      cpu_ready  <= 1'b1;
      cpu_rvalid <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      s0_req     <= 1'b0;
      s1_req     <= 1'b0;
    end else begin
      cpu_rvalid <= 1'b0;
      cpu_err    <= 1'b0;
      if (state == ST_IDLE) begin
        if (cpu_req) begin
          lat_sel   <= dec_sel;
          lat_we    <= cpu_we;
          lat_addr  <= cpu_addr;
          lat_wdata <= cpu_wdata;
          lat_be    <= cpu_be;
          cnt       <= '0;
          cpu_ready <= 1'b0;
          s0_req    <= ~dec_sel;
          s1_req    <= dec_sel;
          state     <= ST_REQ;
        end
      end else if (rsp_ok || to_hit) begin
        // A response in the watchdog's last cycle still completes normally.
        cpu_rvalid <= 1'b1;
        cpu_err    <= ~rsp_ok;
        cpu_rdata  <= rsp_ok ? sel_rdata : ERR_DATA;
        cpu_ready  <= 1'b1;
        s0_req     <= 1'b0;
        s1_req     <= 1'b0;
        state      <= ST_IDLE;
      end else begin
        if (cnt != TO_MAX) cnt <= cnt + 1'b1;
        if ((state == ST_REQ) && sel_ack) begin
          s0_req <= 1'b0;
          s1_req <= 1'b0;
          state  <= ST_RESP;
        end
      end
    end
  end

endmodule
